// File: rtl/accumulator_unit_if.sv
// rtl/accumulator_unit_if.sv - command, bus-input and status bundle for accumulator_unit
interface accumulator_unit_if #(
    parameter int WIDTH      = 8,
    parameter int SHIFT_BITS = 3
);
    logic                  i_load_enable;
    logic                  i_add_enable;
    logic                  i_sub_enable;
    logic                  i_shift_start;
    logic                  i_shift_dir;
    logic [SHIFT_BITS-1:0] i_shift_amt;
    logic                  i_send_enable;
    logic [WIDTH-1:0]      i_bus;
    logic [WIDTH-1:0]      o_unbuffered_out;
    logic                  o_carry;
    logic                  o_zero;
    logic                  o_negative;
    logic                  o_busy;

    modport master (
        output i_load_enable, i_add_enable, i_sub_enable, i_shift_start,
               i_shift_dir, i_shift_amt, i_send_enable, i_bus,
        input  o_unbuffered_out, o_carry, o_zero, o_negative, o_busy
    );

    modport slave (
        input  i_load_enable, i_add_enable, i_sub_enable, i_shift_start,
               i_shift_dir, i_shift_amt, i_send_enable, i_bus,
        output o_unbuffered_out, o_carry, o_zero, o_negative, o_busy
    );
endinterface

// File: rtl/accumulator_unit.sv
// rtl/accumulator_unit.sv - WIDTH-bit bus accumulator with load/add/sub and multi-cycle shift
module accumulator_unit #(
    parameter int WIDTH      = 8,
    parameter int SHIFT_BITS = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_debug,
    accumulator_unit_if.slave    bus_if,
    output wire  [WIDTH-1:0]     o_bus
);
    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t                r_state, w_next_state;
    logic [WIDTH-1:0]      r_acc, w_next_acc;
    logic                  r_carry, w_next_carry;
    logic                  r_dir, w_next_dir;
    logic [SHIFT_BITS-1:0] r_cnt, w_next_cnt;
    logic [WIDTH:0]        w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, bus_if.i_bus};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_dir   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_acc   <= w_next_acc;
            r_carry <= w_next_carry;
            r_dir   <= w_next_dir;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_acc   = r_acc;
        w_next_carry = r_carry;
        w_next_dir   = r_dir;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus_if.i_load_enable) begin
                    w_next_acc = bus_if.i_bus;
                end else if (bus_if.i_add_enable) begin
                    {w_next_carry, w_next_acc} = w_sum;
                end else if (bus_if.i_sub_enable) begin
                    w_next_acc   = r_acc - bus_if.i_bus;
                    w_next_carry = (r_acc >= bus_if.i_bus);
                end else if (bus_if.i_shift_start && (bus_if.i_shift_amt != '0)) begin
                    w_next_dir   = bus_if.i_shift_dir;
                    w_next_cnt   = bus_if.i_shift_amt;
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Commands are dropped here; only the shift sequence advances.
                if (r_dir) begin
                    w_next_carry = r_acc[0];
                    w_next_acc   = r_acc >> 1;
                end else begin
                    w_next_carry = r_acc[WIDTH-1];
                    w_next_acc   = r_acc << 1;
                end
                w_next_cnt = r_cnt - 1'b1;
                if (r_cnt == SHIFT_BITS'(1)) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign o_bus                   = bus_if.i_send_enable ? r_acc : {WIDTH{1'bz}};
    assign bus_if.o_unbuffered_out = r_acc;
    assign bus_if.o_carry          = r_carry;
    assign bus_if.o_zero           = (r_acc == '0);
    assign bus_if.o_negative       = r_acc[WIDTH-1];
    assign bus_if.o_busy           = (r_state == S_SHIFT);

`ifndef SYNTHESIS
    always @(posedge i_clk or negedge i_reset_n) begin
        if (i_debug) begin
            if (!i_reset_n) begin
                $display("accumulator_unit: reset");
            end else if (r_state == S_IDLE) begin
                if (bus_if.i_load_enable)
                    $display("accumulator_unit: load %h", bus_if.i_bus);
                else if (bus_if.i_add_enable)
                    $display("accumulator_unit: add %h + %h", r_acc, bus_if.i_bus);
                else if (bus_if.i_sub_enable)
                    $display("accumulator_unit: sub %h - %h", r_acc, bus_if.i_bus);
                else if (bus_if.i_shift_start && (bus_if.i_shift_amt != '0))
                    $display("accumulator_unit: shift dir=%0d amt=%0d",
                             bus_if.i_shift_dir, bus_if.i_shift_amt);
            end
        end
    end
`endif
endmodule

// File: tb/tb_accumulator_unit.sv
// tb/tb_accumulator_unit.sv - randomized self-checking bench for accumulator_unit
module tb_accumulator_unit;
    localparam int W  = 8;
    localparam int SB = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         debug;
    wire  [W-1:0] bus_out;

    int errors = 0;
    int checks = 0;

    int m_acc;
    int m_carry;

    accumulator_unit_if #(.WIDTH(W), .SHIFT_BITS(SB)) ifc ();

    accumulator_unit #(.WIDTH(W), .SHIFT_BITS(SB)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_debug   (debug),
        .bus_if    (ifc.slave),
        .o_bus     (bus_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifc.i_load_enable = 1'b0;
        ifc.i_add_enable  = 1'b0;
        ifc.i_sub_enable  = 1'b0;
        ifc.i_shift_start = 1'b0;
        ifc.i_shift_dir   = 1'b0;
        ifc.i_shift_amt   = '0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".acc"},   32'(ifc.o_unbuffered_out), 32'(m_acc));
        check({tag, ".carry"}, 32'(ifc.o_carry),          32'(m_carry));
        check({tag, ".zero"},  32'(ifc.o_zero),           32'(m_acc == 0));
        check({tag, ".neg"},   32'(ifc.o_negative),       32'((m_acc >> (W-1)) & 1));
        check({tag, ".busy"},  32'(ifc.o_busy),           32'd0);
    endtask

    // Applies one IDLE-state command, updates the reference model and follows any shift to its end.
    task automatic apply(input bit ld, input bit ad, input bit sb, input bit st,
                         input bit dir, input int amt, input int val, input string tag);
        int cyc;
        ifc.i_load_enable = ld;
        ifc.i_add_enable  = ad;
        ifc.i_sub_enable  = sb;
        ifc.i_shift_start = st;
        ifc.i_shift_dir   = dir;
        ifc.i_shift_amt   = SB'(amt);
        ifc.i_bus         = W'(val);
        step();
        idle_inputs();
        if (ld) begin
            m_acc = val;
        end else if (ad) begin
            m_carry = ((m_acc + val) >= 256) ? 1 : 0;
            m_acc   = (m_acc + val) % 256;
        end else if (sb) begin
            m_carry = (m_acc >= val) ? 1 : 0;
            m_acc   = (m_acc - val + 256) % 256;
        end else if (st && amt != 0) begin
            if (dir) begin
                m_carry = (m_acc >> (amt - 1)) & 1;
                m_acc   = m_acc >> amt;
            end else begin
                m_carry = (m_acc >> (W - amt)) & 1;
                m_acc   = (m_acc << amt) % 256;
            end
            cyc = 0;
            while (ifc.o_busy === 1'b1 && cyc < 64) begin
                // Bus traffic during the shift must be ignored.
                ifc.i_load_enable = 1'b1;
                ifc.i_bus         = W'($urandom);
                cyc++;
                step();
            end
            idle_inputs();
            check({tag, ".busy_cycles"}, 32'(cyc), 32'(amt));
        end
        check_state(tag);
    endtask

    initial begin
        int val, amt;
        bit ld, ad, sb, st, dir;
        debug             = 1'b0;
        ifc.i_send_enable = 1'b0;
        ifc.i_bus         = '0;
        idle_inputs();
        m_acc   = 0;
        m_carry = 0;
        rst_n   = 1'b0;
        step();
        step();
        check_state("reset");
        rst_n = 1'b1;
        step();

        apply(1, 0, 0, 0, 0, 0, 8'hA5, "load_a5");

        apply(1, 0, 0, 0, 0, 0, 8'h3C, "load_3c");
        ifc.i_send_enable = 1'b1;
        #1;
        check("send_on", 32'(bus_out), 32'h3C);
        ifc.i_send_enable = 1'b0;
        #1;
        check("send_off_released", 32'(bus_out !== 8'h3C), 32'd1);
        check("unbuf_during_send_off", 32'(ifc.o_unbuffered_out), 32'h3C);

        apply(1, 0, 0, 0, 0, 0, 8'hF0, "load_f0");
        apply(0, 1, 0, 0, 0, 0, 8'h20, "add_ovf");
        apply(0, 1, 0, 0, 0, 0, 8'h01, "add_nc");

        apply(1, 0, 0, 0, 0, 0, 8'h05, "load_05");
        apply(0, 0, 1, 0, 0, 0, 8'h07, "sub_borrow");
        apply(0, 0, 1, 0, 0, 0, 8'hFE, "sub_zero");

        apply(1, 0, 0, 0, 0, 0, 8'h81, "load_81a");
        apply(0, 0, 0, 1, 0, 3, 8'h00, "shl3");
        check("shl3_result", 32'(ifc.o_unbuffered_out), 32'h08);
        apply(1, 0, 0, 0, 0, 0, 8'h81, "load_81b");
        apply(0, 0, 0, 1, 1, 1, 8'h00, "shr1");
        check("shr1_result", 32'(ifc.o_unbuffered_out), 32'h40);
        apply(0, 0, 0, 1, 1, 0, 8'h00, "shift_n0");

        apply(1, 1, 0, 0, 0, 0, 8'h11, "load_beats_add");
        check("load_beats_add_val", 32'(ifc.o_unbuffered_out), 32'h11);
        apply(0, 1, 1, 1, 0, 2, 8'h22, "add_beats_sub");

        ifc.i_shift_start = 1'b1;
        ifc.i_shift_dir   = 1'b0;
        ifc.i_shift_amt   = 3'd7;
        step();
        idle_inputs();
        step();
        rst_n = 1'b0;
        #2;
        m_acc   = 0;
        m_carry = 0;
        check("abort.acc",  32'(ifc.o_unbuffered_out), 32'd0);
        check("abort.busy", 32'(ifc.o_busy),           32'd0);
        check("abort.zero", 32'(ifc.o_zero),           32'd1);
        step();
        rst_n = 1'b1;
        step();
        check_state("after_abort");

        for (int i = 0; i < 150; i++) begin
            ld  = ($urandom_range(0, 3) == 0);
            ad  = ($urandom_range(0, 2) == 0);
            sb  = ($urandom_range(0, 2) == 0);
            st  = ($urandom_range(0, 1) == 0);
            dir = 1'($urandom);
            amt = $urandom_range(0, 7);
            val = $urandom_range(0, 255);
            apply(ld, ad, sb, st, dir, amt, val, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
